// File: rtl/restoring_divider_unsigned.sv
// Radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional `DIV_OVF_CHECK_EN short-circuits operands whose quotient would not fit in WIDTH bits.
module restoring_divider_unsigned #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 dbz,
   output logic                 ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt;
   logic             dbz_q;
   logic             ovf_q;
   logic             big;

   // rem_q always stays below the divisor, so its top (W-th) bit is implicitly 0.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};

`ifdef DIV_OVF_CHECK_EN
   assign big = (divisor != '0) && (dividend[2*WIDTH-1:WIDTH] >= divisor);
`else
   assign big = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt       <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  busy  <= 1'b1;
                  dvs_q <= divisor;
                  cnt   <= '0;
                  dbz_q <= 1'b0;
                  ovf_q <= 1'b0;
                  if (divisor == '0) begin
                     quo_q <= '1;
                     rem_q <= dividend[WIDTH-1:0];
                     dbz_q <= 1'b1;
                     state <= DONE;
                  end else if (big) begin
                     quo_q <= '1;
                     rem_q <= '0;
                     ovf_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     rem_q <= dividend[2*WIDTH-1:WIDTH];
                     quo_q <= dividend[WIDTH-1:0];
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               // Sign bit of the W+1-bit trial decides subtract vs. restore.
               if (!trial[WIDTH]) begin
                  rem_q <= trial[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= shifted[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1))
                  state <= DONE;
            end
            DONE: begin
               // busy stays high through the done cycle and drops with it in IDLE.
               quotient  <= quo_q;
               remainder <= rem_q;
               dbz       <= dbz_q;
               ovf       <= ovf_q;
               done      <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider_unsigned.sv
// Directed bench for restoring_divider_unsigned (WIDTH=16): vector table plus
// hand-written busy-start, mid-run reset and multiply-back sequences.
module tb_restoring_divider_unsigned;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic           busy, done, dbz, ovf;
   logic [W-1:0]   quotient, remainder;

   int n_pass = 0;
   int n_total = 0;

   restoring_divider_unsigned #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .dbz(dbz), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] dd;
      logic [W-1:0]   dv;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      logic           z;
      int             lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   // Issues one operation, returns cycles from the accept edge to done (100 = timeout).
   task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv, output int lat);
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic chk_pulse_end(input string name);
      @(posedge clk);
      #1;
      chk({name, "_done_fall"}, 32'(done), 32'd0);
      chk({name, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t vecs[9];
      int   lat;
      int   pulses;
      int   first_k;
      logic [W-1:0] q_at, r_at;
      logic         z_at;

      vecs[0] = '{32'd100000,     16'd300,    16'd333,    16'd100,    1'b0, 17};
      vecs[1] = '{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 17};
      vecs[2] = '{32'h12345678,   16'h0000,   16'hFFFF,   16'h5678,   1'b1, 1};
      vecs[3] = '{32'd0,          16'd7,      16'd0,      16'd0,      1'b0, 17};
      vecs[4] = '{32'h0000FFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0, 17};
      vecs[5] = '{32'd1000,       16'd1001,   16'd0,      16'd1000,   1'b0, 17};
      vecs[6] = '{32'hFFFEFFFF,   16'hFFFF,   16'hFFFF,   16'hFFFE,   1'b0, 17};
      vecs[7] = '{32'd0,          16'd0,      16'hFFFF,   16'd0,      1'b1, 1};
      vecs[8] = '{32'd123456,     16'd789,    16'd156,    16'd372,    1'b0, 17};

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q",    32'(quotient), 32'd0);
      chk("rst_r",    32'(remainder), 32'd0);
      chk("rst_dbz",  32'(dbz), 32'd0);
      chk("rst_ovf",  32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].dd, vecs[i].dv, lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_q", i),   32'(quotient), 32'(vecs[i].q));
         chk($sformatf("v%0d_r", i),   32'(remainder), 32'(vecs[i].r));
         chk($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].z));
         chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'd0);
         chk_pulse_end($sformatf("v%0d", i));
         chk($sformatf("v%0d_q_hold", i), 32'(quotient), 32'(vecs[i].q));
      end

      // Quotient-overflow operands.
      run_op(32'h00010000, 16'd1, lat);
`ifdef DIV_OVF_CHECK_EN
      chk("ovf_lat", 32'(lat), 32'd1);
      chk("ovf_flag", 32'(ovf), 32'd1);
      chk("ovf_q", 32'(quotient), 32'hFFFF);
      chk("ovf_r", 32'(remainder), 32'd0);
`else
      chk("ovf_lat", 32'(lat), 32'd17);
      chk("ovf_flag", 32'(ovf), 32'd0);
`endif
      chk("ovf_dbz", 32'(dbz), 32'd0);
      chk_pulse_end("ovf");

      // Start pulsed 5 cycles into a RUN must be ignored.
      @(negedge clk);
      dividend = 32'd100000; divisor = 16'd300; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      pulses = 0; first_k = 0; q_at = '0; r_at = '0; z_at = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            if (pulses == 1) begin
               first_k = k; q_at = quotient; r_at = remainder; z_at = dbz;
            end
         end
         if (k == 5) begin
            dividend = 32'h12345678; divisor = 16'd0; start = 1'b1;
         end else if (k == 6) begin
            start = 1'b0;
         end
      end
      chk("busy_start_pulses", 32'(pulses), 32'd1);
      chk("busy_start_lat", 32'(first_k), 32'd17);
      chk("busy_start_q", 32'(q_at), 32'd333);
      chk("busy_start_r", 32'(r_at), 32'd100);
      chk("busy_start_dbz", 32'(z_at), 32'd0);

      // Reset mid-RUN discards the operation.
      @(negedge clk);
      dividend = 32'd100000; divisor = 16'd300; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_q", 32'(quotient), 32'd0);
      chk("midrst_r", 32'(remainder), 32'd0);
      chk("midrst_dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      chk("midrst_no_done", 32'(pulses), 32'd0);
      run_op(32'd100000, 16'd300, lat);
      chk("postrst_lat", 32'(lat), 32'd17);
      chk("postrst_q", 32'(quotient), 32'd333);
      chk("postrst_r", 32'(remainder), 32'd100);

      // Multiply-back: P = A*B divided by B returns A, remainder 0.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0]   a, b;
         logic [2*W-1:0] p;
         a = W'($urandom);
         b = W'($urandom_range(1, 65535));
         p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         run_op(p, b, lat);
         chk($sformatf("mb%0d_q a=%0h b=%0h", i, a, b), 32'(quotient), 32'(a));
         chk($sformatf("mb%0d_r", i), 32'(remainder), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
